system_timer: RTL and testbench
===============================

Name: system_timer

Overview:
- 64-bit down-counting system tick timer with a memory-mapped 32-bit register interface and a level interrupt output.
- Sits on the processor peripheral bus.
- Reloads from a 64-bit LOAD register on terminal count.
- Sets a sticky COUNTFLAG on each terminal count and raises irq when tick interrupts are enabled.

Parameters:
- LOAD_RST, 64'h0, reset value of the LOAD register; the counter resets to this value.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- sel  input  1  peripheral select; qualifies every read side effect and every write.
- addr  input  3  register index (word address).
- wdata  input  32  write data.
- wen  input  1  write enable; a write occurs on the rising edge when sel=1 and wen=1.
- rdata  output  32  read data, combinational from addr.
- irq  output  1  interrupt request, level.

Behaviour:
Register map (addr):
- 0 CTRL: bit0 ENABLE (RW), bit1 TICKINT (RW), bit16 COUNTFLAG (RO, sticky). All other bits read 0.
- 1 LOAD_L: LOAD[31:0], RW.
- 2 VAL_L: counter[31:0].
- 3 LOAD_H: LOAD[63:32], RW.
- 4 VAL_H: counter[63:32].
- Addresses 5-7 read 0. Writes to them are ignored.

Reset (rst=1 at a clock edge):
- ENABLE=0, TICKINT=0, COUNTFLAG=0, LOAD=LOAD_RST, counter=LOAD_RST.
- irq=0.
- rdata follows the register values, so every valid address reads 0 with the default parameter.

Reads:
- rdata is a pure combinational mux of addr. It is valid in the same cycle addr changes and is driven regardless of sel.

Writes (sel & wen):
- CTRL write updates ENABLE and TICKINT only. COUNTFLAG is unaffected.
- A write to VAL_L or VAL_H, with any data:
  - counter <= LOAD, taking effect next cycle;
  - COUNTFLAG <= 0.

Counting (ENABLE=1, no VAL write this cycle):
- counter != 0: counter <= counter - 1.
- counter == 0: counter <= LOAD and COUNTFLAG <= 1.
- The wrap period is LOAD+1 cycles. LOAD=0 gives a flag set every cycle.
- ENABLE=0: the counter holds its value.

Read-clear:
- An edge with sel=1, wen=0, addr=0 clears COUNTFLAG.
- Reads of VAL_L, VAL_H, LOAD_L and LOAD_H have no side effects.

Priority for COUNTFLAG in the same cycle, highest first:
- VAL write (clear);
- terminal count (set);
- CTRL read-clear.
- Net effect: a terminal count coinciding with a CTRL read leaves the flag set, so no event is lost.

Counter priority:
- A VAL write reload wins over a decrement or terminal reload in the same cycle.

LOAD writes:
- These do not touch the running counter; the new value is used at the next reload.

irq:
- irq = COUNTFLAG & TICKINT, registered-state based with no combinational path from the bus.
- Clearing TICKINT drops irq immediately; COUNTFLAG stays set.

Optional Feature:
- SYSTIMER_SNAPSHOT_EN defined:
  - An edge with sel=1, wen=0, addr=2 (VAL_L read) latches counter[63:32] into a 32-bit shadow register.
  - VAL_H reads return the shadow, so a VAL_L-then-VAL_H read pair is atomic.
  - The shadow resets to 0 and is also loaded with LOAD[63:32] on a VAL write.
- Undefined: VAL_H returns live counter[63:32] and no shadow register exists.

Test Plan:
1. Reset, then sel=1 and read addr 0,1,3,2,4 -> all return 0x00000000, irq=0.
2. Write LOAD_L=0x23456789, LOAD_H=0x00000001, then write VAL_L=0 with ENABLE=0 -> VAL_L=0x23456789, VAL_H=0x00000001, CTRL=0x0.
3. Write LOAD_L=0x30, LOAD_H=0, write VAL_L, write CTRL=0x3, then deselect -> counter reaches 0 after 0x31 cycles, irq=1, CTRL reads 0x00010003; one CTRL read cycle with wen=0 -> CTRL=0x00000003, irq=0.
4. With the flag set, write VAL_L=0xABCD -> COUNTFLAG=0 (CTRL=0x3), counter reloaded to LOAD.
5. Disable, write LOAD_L=2, write VAL_L, enable with CTRL=0x3, wait for irq, read VAL_L -> CTRL still 0x00010003 (VAL reads do not clear).
6. Write CTRL=0x1, write VAL_L, wait 5 cycles -> CTRL=0x00010001 and irq=0. Then a terminal count in the same cycle as a CTRL read -> flag remains 1.

Source files
------------

// File: rtl/system_timer.sv
// system_timer: 64-bit down-counting tick timer, 32-bit register bus, level irq; SYSTIMER_SNAPSHOT_EN adds an atomic VAL_H shadow
module system_timer #(
  parameter logic [63:0] LOAD_RST = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  input  logic        wen,
  output logic [31:0] rdata,
  output logic        irq
);
  logic        enable, tickint, countflag;
  logic [63:0] load, counter;
  logic        wr, val_wr, ctrl_rd, tc;
  logic [31:0] val_h;
  assign wr      = sel & wen;
  assign val_wr  = wr & (addr == 3'd2 | addr == 3'd4);
  assign ctrl_rd = sel & ~wen & (addr == 3'd0);
  assign tc      = enable & ~val_wr & (counter == 64'd0);
  assign irq     = countflag & tickint;
  always_ff @(posedge clk)
    if (rst) begin
      enable    <= 1'b0;
      tickint   <= 1'b0;
      countflag <= 1'b0;
      load      <= LOAD_RST;
      counter   <= LOAD_RST;
    end else begin
      if (wr & addr == 3'd0) begin
        enable  <= wdata[0];
        tickint <= wdata[1];
      end
      if (wr & addr == 3'd1) load[31:0] <= wdata;
      if (wr & addr == 3'd3) load[63:32] <= wdata;
      counter   <= (val_wr | tc) ? load : enable ? counter - 64'd1 : counter;
      countflag <= val_wr ? 1'b0 : tc ? 1'b1 : ctrl_rd ? 1'b0 : countflag;
    end
`ifdef SYSTIMER_SNAPSHOT_EN
  logic [31:0] shadow;
  always_ff @(posedge clk)
    if (rst) shadow <= '0;
    else if (val_wr) shadow <= load[63:32];
    else if (sel & ~wen & addr == 3'd2) shadow <= counter[63:32];
  assign val_h = shadow;
`else
  assign val_h = counter[63:32];
`endif
  always_comb begin
    rdata = '0;
    case (addr)
      3'd0: rdata = {15'd0, countflag, 14'd0, tickint, enable};
      3'd1: rdata = load[31:0];
      3'd2: rdata = counter[31:0];
      3'd3: rdata = load[63:32];
      3'd4: rdata = val_h;
      default: rdata = '0;
    endcase
  end
endmodule

// File: tb/tb_system_timer.sv
// tb_system_timer: directed plus random checks of system_timer against a behavioural register/counter model
module tb_system_timer;
  logic        clk = 1'b0;
  logic        rst, sel, wen, irq;
  logic [2:0]  addr;
  logic [31:0] wdata, rdata;
  int n_chk = 0, n_fail = 0;
  bit chk_on = 1'b0;
  bit          m_en, m_ti, m_flag;
  logic [63:0] m_load, m_cnt;
  logic [31:0] m_sh;

  system_timer dut (.clk(clk), .rst(rst), .sel(sel), .addr(addr), .wdata(wdata),
                    .wen(wen), .rdata(rdata), .irq(irq));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return (32'(m_flag) << 16) | (32'(m_ti) << 1) | 32'(m_en);
      3'd1: return m_load[31:0];
      3'd2: return m_cnt[31:0];
      3'd3: return m_load[63:32];
`ifdef SYSTIMER_SNAPSHOT_EN
      3'd4: return m_sh;
`else
      3'd4: return m_cnt[63:32];
`endif
      default: return 32'd0;
    endcase
  endfunction

  // One clock edge of the timer as described by its register rules
  task automatic model_step();
    bit vw, rc, wrap;
    logic [63:0] ncnt;
    if (rst) begin
      {m_en, m_ti, m_flag} = 3'b000;
      m_load = 64'd0; m_cnt = 64'd0; m_sh = 32'd0;
      return;
    end
    vw   = sel && wen && (addr == 3'd2 || addr == 3'd4);
    rc   = sel && !wen && addr == 3'd0;
    wrap = m_en && !vw && m_cnt == 64'd0;
    if (vw) ncnt = m_load;
    else if (!m_en) ncnt = m_cnt;
    else ncnt = (m_cnt == 64'd0) ? m_load : m_cnt - 64'd1;
    if (vw) m_sh = m_load[63:32];
    else if (sel && !wen && addr == 3'd2) m_sh = m_cnt[63:32];
    if (vw) m_flag = 1'b0;
    else if (wrap) m_flag = 1'b1;
    else if (rc) m_flag = 1'b0;
    if (sel && wen && addr == 3'd0) begin m_en = wdata[0]; m_ti = wdata[1]; end
    if (sel && wen && addr == 3'd1) m_load[31:0] = wdata;
    if (sel && wen && addr == 3'd3) m_load[63:32] = wdata;
    m_cnt = ncnt;
  endtask

  task automatic cyc(input logic s, input logic w, input logic [2:0] a, input logic [31:0] d);
    sel = s; wen = w; addr = a; wdata = d;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b1, a, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 3'd0, 32'd0);
  endtask

  task automatic peek(input string nm, input logic [2:0] a, input logic [31:0] exp);
    sel = 1'b0; wen = 1'b0; addr = a;
    #1;
    check(nm, rdata, exp);
  endtask

  always @(negedge clk)
    if (chk_on) begin
      check("model_rdata", rdata, m_read(addr));
      check("model_irq", 32'(irq), 32'(m_flag & m_ti));
    end

  initial begin
    rst = 1'b1; sel = 1'b0; wen = 1'b0; addr = 3'd0; wdata = 32'd0;
    idle(2);
    rst = 1'b0;
    chk_on = 1'b1;
    peek("rst_ctrl", 3'd0, 32'h0);
    peek("rst_load_l", 3'd1, 32'h0);
    peek("rst_load_h", 3'd3, 32'h0);
    peek("rst_val_l", 3'd2, 32'h0);
    peek("rst_val_h", 3'd4, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    wr(3'd1, 32'h23456789); wr(3'd3, 32'h1); wr(3'd2, 32'h0);
    peek("reload_val_l", 3'd2, 32'h23456789);
    peek("reload_val_h", 3'd4, 32'h1);
    peek("reload_ctrl", 3'd0, 32'h0);
    wr(3'd1, 32'h30); wr(3'd3, 32'h0); wr(3'd2, 32'h0); wr(3'd0, 32'h3);
    idle(32'h30);
    peek("count_zero", 3'd2, 32'h0);
    check("irq_before_tc", 32'(irq), 32'h0);
    idle(1);
    check("irq_at_tc", 32'(irq), 32'h1);
    peek("ctrl_flag", 3'd0, 32'h00010003);
    peek("val_after_wrap", 3'd2, 32'h30);
    cyc(1'b1, 1'b0, 3'd0, 32'h0);
    peek("ctrl_rdclr", 3'd0, 32'h3);
    check("irq_rdclr", 32'(irq), 32'h0);
    idle(32'h30);
    peek("flag_again", 3'd0, 32'h00010003);
    wr(3'd2, 32'hABCD);
    peek("valwr_clr", 3'd0, 32'h3);
    peek("valwr_reload", 3'd2, 32'h30);
    wr(3'd0, 32'h0); wr(3'd1, 32'h2); wr(3'd2, 32'h0); wr(3'd0, 32'h3);
    begin
      int k = 0;
      while (!irq && k < 20) begin idle(1); k++; end
      check("irq_timeout", 32'(irq), 32'h1);
    end
    cyc(1'b1, 1'b0, 3'd2, 32'h0);
    peek("val_rd_noclr", 3'd0, 32'h00010003);
    wr(3'd0, 32'h1);
    check("tickint_off_irq", 32'(irq), 32'h0);
    wr(3'd2, 32'h0);
    idle(5);
    peek("flag_no_tickint", 3'd0, 32'h00010001);
    check("irq_no_tickint", 32'(irq), 32'h0);
    peek("cnt_at_zero", 3'd2, 32'h0);
    cyc(1'b1, 1'b0, 3'd0, 32'h0);
    cyc(1'b1, 1'b0, 3'd0, 32'h0);
    peek("flag_cleared", 3'd0, 32'h1);
    cyc(1'b1, 1'b0, 3'd0, 32'h0);
    cyc(1'b1, 1'b0, 3'd0, 32'h0);
    peek("tc_beats_rdclr", 3'd0, 32'h00010001);
    for (int i = 0; i < 4000; i++) begin
      logic [2:0]  a;
      logic [31:0] d;
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if (a == 3'd1) d = 32'($urandom_range(0, 12));
      if (a == 3'd3) d = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(1, 3)) : 32'd0;
      if (a == 3'd0 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
      rst = ($urandom_range(0, 999) == 0);
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), a, d);
    end
    rst = 1'b0;
    idle(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
